// File: rtl/udp_rx_pkg.sv
// Shared definitions for the UDP receive packet scheduler: FSM state encoding,
// default geometry and the drop-counter saturation value.
package udp_rx_pkg;

  localparam int unsigned ADDR_W_DEF   = 11;
  localparam int unsigned IDLE_TO_DEF  = 64;
  localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_DROP,
    S_COMMIT
  } state_e;

endpackage

// File: rtl/udp_bank_tracker.sv
// Two-bank ping-pong occupancy tracker: full flags, committed lengths and the
// write/read bank pointers. Banks fill and drain strictly alternately.
module udp_bank_tracker (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_commit,
  input  logic [15:0] i_commit_len,
  input  logic        i_done,
  output logic        o_wr_bank,
  output logic        o_wr_full,
  output logic        o_rd_bank,
  output logic        o_pkt_valid,
  output logic [15:0] o_pkt_len
);

  logic [1:0]  r_full;
  logic [15:0] r_len [2];
  logic        r_wr_bank;
  logic        r_rd_bank;
  logic        w_release;

  // pkt_done only counts while a packet is actually presented
  assign w_release = i_done & r_full[r_rd_bank];

  // Commit fills the write bank, release frees the read bank; they never target the same bank
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_full    <= 2'b00;
      r_len[0]  <= 16'd0;
      r_len[1]  <= 16'd0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      if (w_release) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= ~r_rd_bank;
      end
      if (i_commit) begin
        r_full[r_wr_bank] <= 1'b1;
        r_len[r_wr_bank]  <= i_commit_len;
        r_wr_bank         <= ~r_wr_bank;
      end
    end
  end

  assign o_wr_bank   = r_wr_bank;
  assign o_wr_full   = r_full[r_wr_bank];
  assign o_rd_bank   = r_rd_bank;
  assign o_pkt_valid = r_full[r_rd_bank];
  assign o_pkt_len   = r_len[r_rd_bank];

endmodule

// File: rtl/udp_rx_pkt_sched.sv
// UDP receive packet scheduler: frames the payload byte stream into a two-bank
// ping-pong packet RAM and hands committed banks to one reader in arrival order.
// Optional feature macro UDP_RX_SCHED_TRUNC_EN: an idle-timeout abort with bytes
// already written commits a truncated packet and pulses pkt_trunc instead of dropping.
module udp_rx_pkt_sched
  import udp_rx_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned IDLE_TO = IDLE_TO_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic [15:0]       rx_length,
  output logic              buf_wr_en,
  output logic [ADDR_W:0]   buf_wr_addr,
  output logic [7:0]        buf_wr_data,
  output logic              pkt_valid,
  output logic              pkt_bank,
  output logic [15:0]       pkt_len,
  input  logic              pkt_done,
  output logic [15:0]       drop_cnt
`ifdef UDP_RX_SCHED_TRUNC_EN
  ,
  output logic              pkt_trunc
`endif
);

  localparam int unsigned IDLE_W  = $clog2(IDLE_TO + 1);
  localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);

  state_e              r_state, w_state_nxt;
  logic [15:0]         r_cnt, w_cnt_nxt;
  logic [15:0]         r_len, w_len_nxt;
  logic [IDLE_W-1:0]   r_idle, w_idle_nxt;
  logic                r_wr_en, w_wr_en_nxt;
  logic [ADDR_W:0]     r_wr_addr, w_wr_addr_nxt;
  logic [7:0]          r_wr_data, w_wr_data_nxt;
  logic [15:0]         r_drop;
  logic                w_drop_inc;
  logic                w_commit;
  logic                w_wr_bank;
  logic                w_wr_full;
  logic                w_rd_bank;
  logic [15:0]         w_cnt_inc;
  logic                w_idle_to;
  logic                w_len_bad;
`ifdef UDP_RX_SCHED_TRUNC_EN
  logic                w_trunc_set;
  logic                r_trunc_pend;
  logic [1:0]          r_trunc_bank;
  logic                r_shown;
`endif

  assign w_cnt_inc = r_cnt + 16'd1;
  assign w_idle_to = (r_idle == IDLE_W'(IDLE_TO - 1));
  assign w_len_bad = (rx_length == 16'd0) || ({1'b0, rx_length} > MAX_LEN);

  udp_bank_tracker u_bank_tracker (
    .i_clk        (clk),
    .i_rstn       (rstn),
    .i_commit     (w_commit),
    .i_commit_len (r_len),
    .i_done       (pkt_done),
    .o_wr_bank    (w_wr_bank),
    .o_wr_full    (w_wr_full),
    .o_rd_bank    (w_rd_bank),
    .o_pkt_valid  (pkt_valid),
    .o_pkt_len    (pkt_len)
  );

  // FSM next-state, counter updates and write-port stage inputs
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_len_nxt     = r_len;
    w_idle_nxt    = r_idle;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_drop_inc    = 1'b0;
    w_commit      = 1'b0;
`ifdef UDP_RX_SCHED_TRUNC_EN
    w_trunc_set   = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          w_len_nxt  = rx_length;
          w_cnt_nxt  = 16'd1;
          w_idle_nxt = '0;
          if (w_len_bad || w_wr_full) begin
            w_drop_inc  = 1'b1;
            w_state_nxt = S_DROP;
          end else begin
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = {w_wr_bank, {ADDR_W{1'b0}}};
            w_wr_data_nxt = rx_data;
            w_state_nxt   = (rx_length == 16'd1) ? S_COMMIT : S_WR;
          end
        end
      end
      S_WR: begin
        if (rx_valid) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = {w_wr_bank, r_cnt[ADDR_W-1:0]};
          w_wr_data_nxt = rx_data;
          w_cnt_nxt     = w_cnt_inc;
          w_idle_nxt    = '0;
          if (w_cnt_inc == r_len) w_state_nxt = S_COMMIT;
        end else if (w_idle_to) begin
`ifdef UDP_RX_SCHED_TRUNC_EN
          // At least the first byte was written when S_IDLE was left
          w_len_nxt   = r_cnt;
          w_trunc_set = 1'b1;
          w_state_nxt = S_COMMIT;
`else
          w_drop_inc  = 1'b1;
          w_state_nxt = S_IDLE;
`endif
        end else begin
          w_idle_nxt = r_idle + IDLE_W'(1);
        end
      end
      S_DROP: begin
        // A zero-length frame has no byte count to finish on; only the timeout ends it
        if ((r_len != 16'd0) && (r_cnt >= r_len)) begin
          w_state_nxt = S_IDLE;
        end else if (rx_valid) begin
          w_cnt_nxt  = w_cnt_inc;
          w_idle_nxt = '0;
        end else if (w_idle_to) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_idle_nxt = r_idle + IDLE_W'(1);
        end
      end
      S_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Byte/idle counters, latched length, registered write port and saturating drop counter
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt     <= 16'd0;
      r_len     <= 16'd0;
      r_idle    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= 8'd0;
      r_drop    <= 16'd0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_len     <= w_len_nxt;
      r_idle    <= w_idle_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      if (w_drop_inc && (r_drop != DROP_CNT_MAX)) r_drop <= r_drop + 16'd1;
    end
  end

`ifdef UDP_RX_SCHED_TRUNC_EN
  // Per-bank truncation flag plus a "already presented" bit so pkt_trunc fires once
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_trunc_pend <= 1'b0;
      r_trunc_bank <= 2'b00;
      r_shown      <= 1'b0;
    end else begin
      if (w_trunc_set)   r_trunc_pend <= 1'b1;
      else if (w_commit) r_trunc_pend <= 1'b0;
      if (w_commit) r_trunc_bank[w_wr_bank] <= r_trunc_pend;
      if (pkt_valid && pkt_done) r_shown <= 1'b0;
      else if (pkt_valid)        r_shown <= 1'b1;
    end
  end

  assign pkt_trunc = pkt_valid & r_trunc_bank[w_rd_bank] & ~r_shown;
`endif

  // rx_valid during the one-cycle commit would be lost; upstream guarantees a gap
  always_ff @(posedge clk) begin
    if (rstn && (r_state == S_COMMIT)) assert (!rx_valid);
  end

  assign buf_wr_en   = r_wr_en;
  assign buf_wr_addr = r_wr_addr;
  assign buf_wr_data = r_wr_data;
  assign pkt_bank    = w_rd_bank;
  assign drop_cnt    = r_drop;

endmodule

// File: tb/tb_udp_rx_pkt_sched.sv
// Self-checking bench for udp_rx_pkt_sched: a frame-level reference model is
// compared against the DUT every cycle, plus literal checks on directed scenarios.
module tb_udp_rx_pkt_sched;

  localparam int AW   = 11;
  localparam int IDLE = 64;
  localparam int CAP  = 2 ** AW;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic [15:0] rx_length = 16'd0;
  logic        pkt_done = 1'b0;
  logic        buf_wr_en;
  logic [AW:0] buf_wr_addr;
  logic [7:0]  buf_wr_data;
  logic        pkt_valid;
  logic        pkt_bank;
  logic [15:0] pkt_len;
  logic [15:0] drop_cnt;
`ifdef UDP_RX_SCHED_TRUNC_EN
  logic        pkt_trunc;
`endif

  always #5 clk = ~clk;

  udp_rx_pkt_sched #(
    .ADDR_W  (AW),
    .IDLE_TO (IDLE)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_length   (rx_length),
    .buf_wr_en   (buf_wr_en),
    .buf_wr_addr (buf_wr_addr),
    .buf_wr_data (buf_wr_data),
    .pkt_valid   (pkt_valid),
    .pkt_bank    (pkt_bank),
    .pkt_len     (pkt_len),
    .pkt_done    (pkt_done),
    .drop_cnt    (drop_cnt)
`ifdef UDP_RX_SCHED_TRUNC_EN
    ,
    .pkt_trunc   (pkt_trunc)
`endif
  );

  int checks = 0;
  int failures = 0;
  int wr_seen = 0;
  int done_req = 0;
  int done_served = 0;
  bit reader_auto = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  bit       mv = 1'b0;
  bit [1:0] m_full;
  int       m_len [2];
  bit       m_wr, m_rd;
  int       m_drop;
  bit       e_we;
  int       e_addr, e_data;
  bit       c_pend, c_bank, c_tr;
  int       c_len;
  int       fr_mode, fr_len, fr_got, fr_idle;  // fr_mode: 0 none, 1 storing, 2 discarding
  bit [1:0] m_tr;
  bit       m_shown;

  task automatic m_commit(input int len, input bit tr);
    c_pend  = 1'b1;
    c_bank  = m_wr;
    c_len   = len;
    c_tr    = tr;
    fr_mode = 0;
  endtask

  task automatic m_drop_inc();
    if (m_drop < 65535) m_drop++;
  endtask

  // Compare outputs against last cycle's prediction, then predict the next cycle
  initial begin
    bit [1:0] old_full;
    forever begin
      @(negedge clk);
      if (mv) begin
        chk("pkt_valid", pkt_valid, m_full[m_rd]);
        chk("pkt_bank", pkt_bank, m_rd);
        chk("pkt_len", pkt_len, m_len[m_rd]);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("buf_wr_en", buf_wr_en, e_we);
        if (e_we) begin
          chk("buf_wr_addr", buf_wr_addr, e_addr);
          chk("buf_wr_data", buf_wr_data, e_data);
        end
`ifdef UDP_RX_SCHED_TRUNC_EN
        chk("pkt_trunc", pkt_trunc, m_full[m_rd] && m_tr[m_rd] && !m_shown);
`endif
        if (buf_wr_en === 1'b1) wr_seen++;
      end
      if (rstn === 1'b0) begin
        mv = 1'b1; m_full = 2'b00; m_len[0] = 0; m_len[1] = 0; m_wr = 0; m_rd = 0;
        m_drop = 0; e_we = 0; e_addr = 0; e_data = 0; c_pend = 0; fr_mode = 0;
        m_tr = 2'b00; m_shown = 0;
      end else if (mv) begin
        old_full = m_full;
        if (pkt_done && m_full[m_rd]) begin
          m_full[m_rd] = 1'b0;
          m_rd = !m_rd;
          m_shown = 1'b0;
        end else if (m_full[m_rd]) begin
          m_shown = 1'b1;
        end
        if (c_pend) begin
          m_full[c_bank] = 1'b1;
          m_len[c_bank]  = c_len;
          m_tr[c_bank]   = c_tr;
          m_wr = !m_wr;
          c_pend = 1'b0;
        end
        e_we = 1'b0;
        case (fr_mode)
          0: if (rx_valid) begin
            fr_len = int'(rx_length); fr_got = 1; fr_idle = 0;
            if (fr_len == 0 || fr_len > CAP || old_full[m_wr]) begin
              fr_mode = 2;
              m_drop_inc();
            end else begin
              e_we = 1; e_addr = m_wr * CAP; e_data = int'(rx_data); fr_mode = 1;
              if (fr_got == fr_len) m_commit(fr_len, 1'b0);
            end
          end
          1: if (rx_valid) begin
            e_we = 1; e_addr = m_wr * CAP + fr_got; e_data = int'(rx_data);
            fr_got++; fr_idle = 0;
            if (fr_got == fr_len) m_commit(fr_len, 1'b0);
          end else begin
            fr_idle++;
            if (fr_idle == IDLE) begin
`ifdef UDP_RX_SCHED_TRUNC_EN
              m_commit(fr_got, 1'b1);
`else
              m_drop_inc();
`endif
              fr_mode = 0;
            end
          end
          default: if (rx_valid) begin
            fr_got++; fr_idle = 0;
            if (fr_got == fr_len) fr_mode = 0;
          end else begin
            fr_idle++;
            if (fr_idle == IDLE) fr_mode = 0;
          end
        endcase
      end
    end
  end

  // ---------------- reader ----------------
  initial begin
    forever begin
      @(posedge clk);
      #1;
      pkt_done = 1'b0;
      if (reader_auto) begin
        pkt_done = (pkt_valid === 1'b1) && ($urandom_range(0, 2) == 0);
      end else if (done_served < done_req && pkt_valid === 1'b1) begin
        pkt_done = 1'b1;
        done_served++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    done_req = done_served;
    rx_valid = 1'b0;
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic send_frame(input int len_f, input int nbytes, input int maxgap,
                            input int hole_at, input int hole_len, input int tail);
    rx_length = 16'(len_f);
    for (int i = 0; i < nbytes; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      step();
      rx_valid = 1'b0;
      if (i == hole_at) repeat (hole_len) step();
      else if (i < nbytes - 1 && maxgap > 0) repeat ($urandom_range(0, maxgap)) step();
    end
    repeat (tail) step();
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    int len;
    do_reset();
    chk("reset_wr_en", buf_wr_en, 0);
    chk("reset_wr_addr", buf_wr_addr, 0);
    chk("reset_wr_data", buf_wr_data, 0);
    chk("reset_pkt_valid", pkt_valid, 0);
    chk("reset_pkt_bank", pkt_bank, 0);
    chk("reset_pkt_len", pkt_len, 0);
    chk("reset_drop_cnt", drop_cnt, 0);

    // 1: single 64-byte frame, released 10 cycles later
    w0 = wr_seen;
    send_frame(64, 64, 0, -1, 0, 2);
    chk("t1_valid", pkt_valid, 1);
    chk("t1_len", pkt_len, 64);
    chk("t1_bank", pkt_bank, 0);
    chk("t1_writes", wr_seen - w0, 64);
    repeat (10) step();
    done_req++;
    repeat (3) step();
    chk("t1_released", pkt_valid, 0);

    // 2: three back-to-back 100-byte frames, no reader
    do_reset();
    for (int f = 0; f < 3; f++) send_frame(100, 100, 2, -1, 0, 2);
    chk("t2_drop", drop_cnt, 1);
    chk("t2_valid", pkt_valid, 1);
    chk("t2_bank", pkt_bank, 0);
    chk("t2_len", pkt_len, 100);
    done_req++;
    repeat (3) step();
    chk("t2_bank_next", pkt_bank, 1);
    chk("t2_valid_next", pkt_valid, 1);
    done_req++;
    repeat (3) step();

    // 3: oversize frame dropped, then a legal frame lands in bank 0
    do_reset();
    w0 = wr_seen;
    send_frame(CAP + 1, CAP + 1, 0, -1, 0, 2);
    chk("t3_drop", drop_cnt, 1);
    chk("t3_no_writes", wr_seen - w0, 0);
    send_frame(8, 8, 1, -1, 0, 2);
    chk("t3_valid", pkt_valid, 1);
    chk("t3_bank", pkt_bank, 0);
    chk("t3_len", pkt_len, 8);

    // 4: 1470-byte frame with a 40-cycle hole survives
    do_reset();
    send_frame(1470, 1470, 0, 700, 40, 3);
    chk("t4_valid", pkt_valid, 1);
    chk("t4_len", pkt_len, 1470);
    chk("t4_drop", drop_cnt, 0);

    // 5: 20 of 50 bytes then silence
    do_reset();
    send_frame(50, 20, 1, -1, 0, IDLE + 30);
`ifdef UDP_RX_SCHED_TRUNC_EN
    chk("t5_valid", pkt_valid, 1);
    chk("t5_len", pkt_len, 20);
    chk("t5_drop", drop_cnt, 0);
`else
    chk("t5_drop", drop_cnt, 1);
    chk("t5_valid", pkt_valid, 0);
`endif

    // 6: reset mid-frame, then an 8-byte frame
    do_reset();
    send_frame(30, 10, 0, -1, 0, 0);
    rstn = 1'b0;
    step();
    step();
    rstn = 1'b1;
    chk("t6_valid_after_reset", pkt_valid, 0);
    chk("t6_drop_after_reset", drop_cnt, 0);
    step();
    send_frame(8, 8, 1, -1, 0, 2);
    chk("t6_valid", pkt_valid, 1);
    chk("t6_bank", pkt_bank, 0);
    chk("t6_len", pkt_len, 8);

    // Randomized traffic with a random-latency reader
    do_reset();
    reader_auto = 1'b1;
    for (int f = 0; f < 60; f++) begin
      int kind;
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 160);
      if (kind == 0) send_frame(len, (len / 2 > 0) ? len / 2 : 1, 3, -1, 0, IDLE + 5);
      else if (kind == 1) send_frame(0, 3, 1, -1, 0, IDLE + 5);
      else if (kind == 2) send_frame(1, 1, 0, -1, 0, $urandom_range(1, 4));
      else send_frame(len, len, 3, -1, 0, $urandom_range(1, 6));
    end
    reader_auto = 1'b0;
    repeat (20) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
